lcd_spi_arbiter: RTL

//  Shares the single LCD spi_master byte channel between NREQ independent drawing engines (pet sprite, status icon, wipe).
//  - Round-robin arbitration at burst granularity: a granted requester keeps the channel until its last-flagged byte completes.
//  - Sits between the requesters and spi_master; drives spi_master data_in/cmd/start and consumes its avail pulse.

---
 rtl/lcd_spi_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_spi_arbiter.sv
// lcd_spi_arbiter
// Shares the single LCD spi_master byte channel between NREQ drawing engines.
// Arbitration is round-robin at burst granularity. The owner keeps the channel
// until its last-flagged byte has been shifted out, until it drops req, or
// until the watchdog fires.
// Optional feature: define LCD_ARB_WDOG_EN to enable the per-byte watchdog
// (WDOG_CYCLES), which is reported on arb_err.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; pick the next requester by round-robin from rr_ptr
// SEND  | owner's byte offered to spi_master (spi_start high after entry)
// GAP   | one-cycle ack to the owner so it can present its next byte

module lcd_spi_arbiter #(
    parameter int NREQ        = 3,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_cmd,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic                arb_busy,
    output logic [7:0]          spi_data,
    output logic                spi_cmd,
    output logic                spi_start,
    input  logic                spi_avail,
    output logic                arb_err
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SCAN_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic               last_q;
    logic [SCAN_W-1:0]  scan;

    logic [7:0]         g_data;
    logic               g_req;
    logic               g_cmd;
    logic               g_last;
    logic               wdog_hit;

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Slice of the current owner's inputs.
    assign g_data   = req_data[{g_idx, 3'b000} +: 8];
    assign g_req    = req[g_idx];
    assign g_cmd    = req_cmd[g_idx];
    assign g_last   = req_last[g_idx];
    assign next_ptr = (g_idx == PTR_W'(NREQ - 1)) ? '0 : g_idx + PTR_W'(1);
    assign arb_busy = |grant;

    // Round-robin scan: first pending requester at rr_ptr, rr_ptr+1, ... mod NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + SCAN_W'(k);
            if (scan >= SCAN_W'(NREQ)) begin
                scan = scan - SCAN_W'(NREQ);
            end
            if (!win_found && req[scan[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[PTR_W-1:0];
            end
        end
    end

`ifdef LCD_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              arb_err_q;

    // The count is taken before this cycle's increment, so a match on
    // WDOG_CYCLES-1 is the cycle in which the count reaches WDOG_CYCLES.
    assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    assign arb_err  = arb_err_q;
`else
    logic [31:0] unused_wdog;

    assign unused_wdog = 32'(WDOG_CYCLES);
    assign wdog_hit    = 1'b0;
    assign arb_err     = 1'b0;
`endif

    // Arbiter FSM. All channel-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            g_idx     <= '0;
            ack       <= '0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            spi_cmd   <= 1'b0;
            last_q    <= 1'b0;
            rr_ptr    <= '0;
`ifdef LCD_ARB_WDOG_EN
            wdog_cnt  <= '0;
            arb_err_q <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef LCD_ARB_WDOG_EN
            arb_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    spi_start <= 1'b0;
                    if (win_found) begin
                        grant <= onehot(win_idx);
                        g_idx <= win_idx;
                        state <= SEND;
`ifdef LCD_ARB_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end
                end

                SEND: begin
                    // An accepted byte wins over a same-cycle req drop:
                    // the byte has already gone out on the wire.
                    if (spi_start && spi_avail) begin
                        spi_start <= 1'b0;
                        ack       <= onehot(g_idx);
                        last_q    <= g_last;
                        state     <= GAP;
                    end else if (!g_req || wdog_hit) begin
                        spi_start <= 1'b0;
                        grant     <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
`ifdef LCD_ARB_WDOG_EN
                        // A requester dropping out is not a watchdog error.
                        arb_err_q <= g_req;
`endif
                    end else begin
                        spi_start <= 1'b1;
                        spi_data  <= g_data;
                        spi_cmd   <= g_cmd;
`ifdef LCD_ARB_WDOG_EN
                        wdog_cnt  <= wdog_cnt + WDOG_W'(1);
`endif
                    end
                end

                GAP: begin
                    // The requester advances its byte during this cycle, so
                    // the slice sampled here is already the next byte.
                    if (last_q || !g_req) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        spi_start <= 1'b1;
                        spi_data  <= g_data;
                        spi_cmd   <= g_cmd;
                        state     <= SEND;
`ifdef LCD_ARB_WDOG_EN
                        wdog_cnt  <= '0;
`endif
                    end
                end

                default: begin
                    spi_start <= 1'b0;
                    grant     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
